// File: rtl/mskaes_in_sharer_pkg.sv
// mskaes_in_sharer_pkg: shared block width and FSM state encoding for the input sharer
package mskaes_in_sharer_pkg;
    localparam int BLK_W = 128;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GATHER = 2'd1;
    localparam logic [1:0] ST_ISSUE  = 2'd2;
    localparam logic [1:0] ST_WAIT   = 2'd3;
endpackage

// File: rtl/mskaes_share_gen.sv
// mskaes_share_gen: combinational d-share bit-interleaved masking of a data word
// ports: data (width) unmasked word, rnd ((d-1)*width) random bits, sh (d*width) shares,
//        share j of bit i sits at sh[d*i+j]; the last share carries data ^ all random shares
module mskaes_share_gen #(
    parameter int d     = 2,
    parameter int width = 128
) (
    input  logic [width-1:0]       data,
    input  logic [(d-1)*width-1:0] rnd,
    output logic [d*width-1:0]     sh
);
    always_comb begin
        sh = '0;
        for (int i = 0; i < width; i++) begin
            for (int j = 0; j < d-1; j++) sh[d*i+j] = rnd[i*(d-1)+j];
            sh[d*i+d-1] = data[i] ^ (^rnd[i*(d-1) +: d-1]);
        end
    end
endmodule

// File: rtl/mskaes_in_sharer.sv
// mskaes_in_sharer: masks an unmasked plaintext/key job with PRNG beats and hands shares to a masked AES core
// ports: clk/rst clock and sync active-high reset; in_valid/in_ready/plaintext/key job input;
//        rnd_in/rnd_valid/rnd_ready PRNG stream; sh_plaintext/sh_key interleaved shares;
//        aes_valid_in/aes_ready start handshake; cipher_valid core done; busy job in flight
module mskaes_in_sharer
    import mskaes_in_sharer_pkg::*;
#(
    parameter int d     = 2,
    parameter int RND_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLK_W-1:0]   plaintext,
    input  logic [BLK_W-1:0]   key,
    input  logic [RND_W-1:0]   rnd_in,
    input  logic               rnd_valid,
    output logic               rnd_ready,
    output logic [BLK_W*d-1:0] sh_plaintext,
    output logic [BLK_W*d-1:0] sh_key,
    output logic               aes_valid_in,
    input  logic               aes_ready,
    input  logic               cipher_valid,
    output logic               busy
);
    localparam int R_W   = 2*BLK_W*(d-1);
    localparam int N     = R_W/RND_W;
    localparam int CNT_W = $clog2(N+1);
    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [R_W-1:0]     r_q, r_nx;
    logic [BLK_W-1:0]   pt_q, key_q;
    logic [BLK_W*d-1:0] sh_pt_nx, sh_key_nx;
    logic               beat, last;
    assign in_ready     = state == ST_IDLE;
    assign rnd_ready    = state == ST_GATHER;
    assign aes_valid_in = state == ST_ISSUE;
    assign busy         = state != ST_IDLE;
    assign beat         = rnd_valid && rnd_ready;
    assign last         = beat && cnt == CNT_W'(N-1);
    // shares are built from R with the current beat merged so the final beat lands in the ISSUE-entry registers
    always_comb begin
        r_nx = r_q;
        if (beat) r_nx[int'(cnt)*RND_W +: RND_W] = rnd_in;
    end
    mskaes_share_gen #(.d(d), .width(BLK_W)) u_pt_gen (
        .data(pt_q),
        .rnd(r_nx[BLK_W*(d-1)-1:0]),
        .sh(sh_pt_nx)
    );
    mskaes_share_gen #(.d(d), .width(BLK_W)) u_key_gen (
        .data(key_q),
        .rnd(r_nx[R_W-1 -: BLK_W*(d-1)]),
        .sh(sh_key_nx)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            r_q          <= '0;
            pt_q         <= '0;
            key_q        <= '0;
            sh_plaintext <= '0;
            sh_key       <= '0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    pt_q  <= plaintext;
                    key_q <= key;
                    cnt   <= '0;
                    state <= ST_GATHER;
                end
                ST_GATHER: if (beat) begin
                    r_q <= r_nx;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        sh_plaintext <= sh_pt_nx;
                        sh_key       <= sh_key_nx;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: if (aes_ready) begin
                    pt_q  <= '0;
                    key_q <= '0;
                    r_q   <= '0;
                    state <= ST_WAIT;
                end
                default: if (cipher_valid) begin
                    sh_plaintext <= '0;
                    sh_key       <= '0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mskaes_in_sharer.sv
// tb_mskaes_in_sharer: directed self-checking bench for mskaes_in_sharer with d=2, RND_W=32
module tb_mskaes_in_sharer;
    logic         clk = 0;
    logic         rst = 1;
    logic         in_valid = 0;
    logic         in_ready;
    logic [127:0] plaintext = '0;
    logic [127:0] key = '0;
    logic [31:0]  rnd_in = '0;
    logic         rnd_valid = 0;
    logic         rnd_ready;
    logic [255:0] sh_plaintext;
    logic [255:0] sh_key;
    logic         aes_valid_in;
    logic         aes_ready = 0;
    logic         cipher_valid = 0;
    logic         busy;
    int checks = 0;
    int errors = 0;
    localparam logic [127:0] P0 = 128'h340737e0a29831318d305a88a8f64332;
    localparam logic [127:0] K0 = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    localparam logic [255:0] R_INC = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555,
                                      32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

    always #5 clk = ~clk;

    mskaes_in_sharer #(.d(2), .RND_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .key(key), .rnd_in(rnd_in), .rnd_valid(rnd_valid),
        .rnd_ready(rnd_ready), .sh_plaintext(sh_plaintext), .sh_key(sh_key),
        .aes_valid_in(aes_valid_in), .aes_ready(aes_ready), .cipher_valid(cipher_valid),
        .busy(busy)
    );

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_job(input logic [127:0] p, input logic [127:0] k);
        in_valid = 1; plaintext = p; key = k;
        step();
        in_valid = 0; plaintext = '0; key = '0;
    endtask

    // beats: inc ? 32'h11111111*(k+1) : pat; toggle starts with an idle cycle
    task automatic gather(input logic [31:0] pat, input bit inc, input bit toggle,
                          input logic cv_at3, output int n, output int avi);
        int k;
        n = 0; avi = 0; k = 0;
        while (rnd_ready && n < 100) begin
            n++;
            if (aes_valid_in) avi++;
            rnd_valid = toggle ? (n % 2 == 0) : 1'b1;
            rnd_in = inc ? 32'h11111111 * (k + 1) : pat;
            cipher_valid = cv_at3 && n == 3;
            if (rnd_valid) k++;
            step();
        end
        rnd_valid = 0; rnd_in = '0; cipher_valid = 0;
    endtask

    task automatic finish_job;
        int n;
        aes_ready = 1;
        step();
        aes_ready = 0;
        n = 0;
        while (busy && n < 20) begin
            cipher_valid = 1;
            step();
            n++;
        end
        cipher_valid = 0;
    endtask

    task automatic test_reset;
        rst = 1; step(); step(); rst = 0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (busy !== 1'b0 || aes_valid_in !== 1'b0 || rnd_ready !== 1'b0) begin errors++; $display("FAIL reset_ctrl got busy=%b avi=%b rr=%b exp 0", busy, aes_valid_in, rnd_ready); end
        checks++; if (sh_plaintext !== '0 || sh_key !== '0) begin errors++; $display("FAIL reset_shares got %h %h exp 0", sh_plaintext, sh_key); end
    endtask

    task automatic test_zero_rnd;
        int n, avi;
        logic [255:0] exp_p;
        for (int i = 0; i < 128; i++) begin exp_p[2*i] = 1'b0; exp_p[2*i+1] = P0[i]; end
        start_job(P0, 128'h0);
        checks++; if (busy !== 1'b1 || rnd_ready !== 1'b1) begin errors++; $display("FAIL zero_enter_gather got busy=%b rr=%b exp 1 1", busy, rnd_ready); end
        gather(32'h0, 0, 0, 0, n, avi);
        checks++; if (n !== 8) begin errors++; $display("FAIL zero_gather_cycles got %0d exp 8", n); end
        checks++; if (aes_valid_in !== 1'b1) begin errors++; $display("FAIL zero_issue got %b exp 1", aes_valid_in); end
        checks++; if (sh_plaintext !== exp_p) begin errors++; $display("FAIL zero_sh_pt got %h exp %h", sh_plaintext, exp_p); end
        checks++; if (sh_key !== '0) begin errors++; $display("FAIL zero_sh_key got %h exp 0", sh_key); end
        finish_job();
        checks++; if (in_ready !== 1'b1 || sh_plaintext !== '0) begin errors++; $display("FAIL zero_done got rdy=%b sh=%h exp 1 0", in_ready, sh_plaintext); end
    endtask

    task automatic test_ones_rnd;
        int n, avi;
        logic [255:0] exp_k;
        logic [127:0] rec;
        for (int i = 0; i < 128; i++) begin exp_k[2*i] = 1'b1; exp_k[2*i+1] = ~K0[i]; end
        start_job(128'h0, K0);
        gather(32'hffffffff, 0, 0, 0, n, avi);
        for (int i = 0; i < 128; i++) rec[i] = sh_key[2*i] ^ sh_key[2*i+1];
        checks++; if (sh_key !== exp_k) begin errors++; $display("FAIL ones_sh_key got %h exp %h", sh_key, exp_k); end
        checks++; if (rec !== K0) begin errors++; $display("FAIL ones_reconstruct got %h exp %h", rec, K0); end
        finish_job();
    endtask

    task automatic test_toggle;
        int n, avi;
        logic [255:0] exp_p, exp_k;
        for (int i = 0; i < 128; i++) begin
            exp_p[2*i] = R_INC[i];     exp_p[2*i+1] = R_INC[i];
            exp_k[2*i] = R_INC[128+i]; exp_k[2*i+1] = R_INC[128+i];
        end
        start_job(128'h0, 128'h0);
        gather(32'h0, 1, 1, 0, n, avi);
        checks++; if (n !== 16) begin errors++; $display("FAIL toggle_gather_cycles got %0d exp 16", n); end
        checks++; if (avi !== 0) begin errors++; $display("FAIL toggle_early_issue got %0d exp 0", avi); end
        checks++; if (aes_valid_in !== 1'b1) begin errors++; $display("FAIL toggle_issue got %b exp 1", aes_valid_in); end
        checks++; if (sh_plaintext !== exp_p || sh_key !== exp_k) begin errors++; $display("FAIL toggle_beat_order got %h %h exp %h %h", sh_plaintext, sh_key, exp_p, exp_k); end
        finish_job();
    endtask

    task automatic test_stall_issue;
        int n, avi, hi, unstable, early_zero;
        logic [255:0] snap_p, snap_k;
        start_job(P0, K0);
        gather(32'h0, 1, 0, 0, n, avi);
        snap_p = sh_plaintext; snap_k = sh_key;
        hi = 0; unstable = 0; early_zero = 0;
        for (int c = 0; c < 6; c++) begin
            if (aes_valid_in) hi++;
            if (sh_plaintext !== snap_p || sh_key !== snap_k) unstable++;
            if (dut.pt_q !== P0 || dut.key_q !== K0 || dut.r_q !== R_INC) early_zero++;
            aes_ready = (c == 5);
            step();
        end
        aes_ready = 0;
        checks++; if (hi !== 6) begin errors++; $display("FAIL stall_valid_cycles got %0d exp 6", hi); end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL stall_shares_unstable got %0d exp 0", unstable); end
        checks++; if (early_zero !== 0) begin errors++; $display("FAIL stall_early_clear got %0d exp 0", early_zero); end
        checks++; if (aes_valid_in !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL stall_wait got avi=%b busy=%b exp 0 1", aes_valid_in, busy); end
        checks++; if (dut.pt_q !== '0 || dut.key_q !== '0 || dut.r_q !== '0) begin errors++; $display("FAIL stall_clear got %h %h exp 0", dut.pt_q, dut.key_q); end
        checks++; if (sh_plaintext !== snap_p || sh_key !== snap_k) begin errors++; $display("FAIL stall_wait_shares got %h exp %h", sh_plaintext, snap_p); end
        cipher_valid = 1; step(); cipher_valid = 0;
    endtask

    task automatic test_reset_mid;
        int n, avi, pulses;
        pulses = 0;
        start_job(P0, K0);
        for (int k = 0; k < 3; k++) begin
            if (aes_valid_in) pulses++;
            rnd_valid = 1; rnd_in = 32'hdead0000 + k;
            step();
        end
        rst = 1; step(); rst = 0; rnd_valid = 0;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || rnd_ready !== 1'b0) begin errors++; $display("FAIL midrst_idle got rdy=%b busy=%b rr=%b exp 1 0 0", in_ready, busy, rnd_ready); end
        checks++; if (dut.r_q !== '0 || dut.pt_q !== '0 || dut.cnt !== '0) begin errors++; $display("FAIL midrst_clear got r=%h pt=%h exp 0", dut.r_q, dut.pt_q); end
        for (int c = 0; c < 3; c++) begin
            if (aes_valid_in) pulses++;
            step();
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_aborted_issue got %0d exp 0", pulses); end
        start_job(P0, K0);
        gather(32'h0, 1, 0, 0, n, avi);
        checks++; if (n !== 8) begin errors++; $display("FAIL midrst_full_gather got %0d exp 8", n); end
        finish_job();
    endtask

    task automatic test_cipher;
        int n, avi;
        start_job(P0, K0);
        gather(32'h0, 0, 0, 1, n, avi);
        checks++; if (n !== 8) begin errors++; $display("FAIL cipher_gather_ignored got %0d exp 8", n); end
        cipher_valid = 1; step(); cipher_valid = 0;
        checks++; if (aes_valid_in !== 1'b1) begin errors++; $display("FAIL cipher_issue_ignored got %b exp 1", aes_valid_in); end
        aes_ready = 1; step(); aes_ready = 0;
        step();
        checks++; if (busy !== 1'b1 || sh_plaintext === '0) begin errors++; $display("FAIL cipher_wait_hold got busy=%b exp 1", busy); end
        cipher_valid = 1; step(); cipher_valid = 0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL cipher_idle got busy=%b rdy=%b exp 0 1", busy, in_ready); end
        checks++; if (sh_plaintext !== '0 || sh_key !== '0) begin errors++; $display("FAIL cipher_zero_shares got %h %h exp 0", sh_plaintext, sh_key); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_zero_rnd();
        test_ones_rnd();
        test_toggle();
        test_stall_issue();
        test_reset_mid();
        test_cipher();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mskaes_in_sharer.md
MSKAES_IN_SHARER -- requirements
Module: mskaes_in_sharer

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- d, 2, number of shares; legal values are d>=2.
- RND_W, 32, PRNG beat width; 256*(d-1) SHALL be divisible by RND_W.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- in_valid, in, 1, an unmasked job is offered.
- in_ready, out, 1, the block can accept a job.
- plaintext, in, 128, unmasked plaintext.
- key, in, 128, unmasked key.
- rnd_in, in, RND_W, PRNG data.
- rnd_valid, in, 1, PRNG data is valid.
- rnd_ready, out, 1, the block consumes a PRNG beat.
- sh_plaintext, out, 128*d, bit-interleaved shared plaintext.
- sh_key, out, 128*d, bit-interleaved shared key.
- aes_valid_in, out, 1, start request to the masked AES core.
- aes_ready, in, 1, the AES core accepts a start.
- cipher_valid, in, 1, the AES core has finished.
- busy, out, 1, a job is in flight.

Function
REQ-004 The FSM SHALL have four states: IDLE, GATHER, ISSUE and WAIT. It SHALL be in IDLE after reset.
REQ-005 in_ready SHALL equal (state==IDLE). A job SHALL be accepted when in_valid and in_ready are both high. On acceptance, the block SHALL latch plaintext and key, clear the beat counter and move to GATHER.
REQ-006 rnd_ready SHALL equal (state==GATHER). Each rnd_valid&&rnd_ready beat k SHALL write rnd_in into randomness buffer R[k*RND_W +: RND_W].
REQ-007 N = 256*(d-1)/RND_W beats SHALL be collected. When beat N-1 is accepted, the FSM SHALL move to ISSUE. Stalls on rnd_valid SHALL not change state. The counter SHALL be ceil(log2(N+1)) bits and SHALL never wrap.
REQ-008 The shares SHALL be formed in the cycle that enters ISSUE and registered, as follows.
- For bit i (0..127) and j<d-1: sh_plaintext[d*i+j] = R[i*(d-1)+j].
- For the same i and j: sh_key[d*i+j] = R[128*(d-1)+i*(d-1)+j].
- The last share SHALL be the data bit XOR the d-1 random bits. For plaintext, sh_plaintext[d*i+d-1] = plaintext[i] ^ XOR of the other shares of that bit; sh_key is formed the same way from key.
REQ-009 The XOR over the d shares of every bit SHALL equal the unmasked bit.
REQ-010 aes_valid_in SHALL be high exactly while in ISSUE. When aes_ready is high in that state, the FSM SHALL move to WAIT. An aes_ready that is low SHALL hold ISSUE indefinitely.
REQ-011 On that same ISSUE->WAIT edge, the latched unmasked plaintext/key registers and R SHALL be zeroed.
REQ-012 sh_plaintext and sh_key SHALL stay stable from entry to ISSUE until the return to IDLE.
REQ-013 In WAIT, cipher_valid high SHALL move the FSM to IDLE on the next edge, and both share outputs SHALL be zeroed on that edge. cipher_valid SHALL be ignored in IDLE, GATHER and ISSUE.
REQ-014 busy SHALL equal (state!=IDLE).
REQ-015 Latency with rnd_valid held high SHALL be as follows, taking the acceptance edge as 0.
- GATHER occupies cycles 1..N.
- aes_valid_in first rises in cycle N+1.

Reset
REQ-016 rst high at any clock edge, including mid-GATHER, mid-ISSUE and mid-WAIT, SHALL drive the following on that edge.
- state to IDLE and all counters to 0.
- R, the latched plaintext/key, sh_plaintext and sh_key to 0.
- aes_valid_in=0 and rnd_ready=0.
- in_ready=1 on the following cycle.
REQ-017 A partially gathered job SHALL be discarded by reset and never issued.

Structure
REQ-018 A shared package SHALL hold the FSM state encoding and the 128-bit block width constant.
REQ-019 Share generation SHALL be one combinational sub-module, mskaes_share_gen. It SHALL be parameterised on d and width, take a data word and (d-1)*width random bits, and return the interleaved shares. It SHALL be instantiated twice, once for plaintext and once for key.

Verification
REQ-020 Zero randomness: d=2, RND_W=32, rnd_in=0, plaintext=340737e0a29831318d305a88a8f64332 -> share0 of every bit=0, share1 of every bit=plaintext bit, 8 GATHER cycles.
REQ-021 rnd_in all-ones, key=3c4fcf098815f7aba6d2ae2816157e2b -> share0=1 and share1=~key bit for every bit; the per-bit XOR reconstructs the key.
REQ-022 rnd_valid toggled every other cycle -> 16 cycles in GATHER, the beats captured in order, aes_valid_in rising only after the 8th beat.
REQ-023 aes_ready held low for 5 cycles in ISSUE -> aes_valid_in high for 6 cycles, shares stable throughout, and the unmasked registers zeroed only after the handshake.
REQ-024 rst pulsed after 3 beats -> the next cycle shows IDLE and in_ready=1; a new job then needs a full 8 beats; aes_valid_in never pulses for the aborted job.
REQ-025 cipher_valid pulsed in GATHER (ignored), then in WAIT -> IDLE one edge after the WAIT pulse, shares zeroed and busy low.
